// File: rtl/dice_pkg.sv
// Shared definitions for the dice game roll button path.
// Holds the debounce FSM state encoding and the roll counter width used by
// roll_button_ctrl and its interface.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_e;

    localparam int ROLL_CNT_W = 8;

endpackage

// File: rtl/roll_button_ctrl_if.sv
// Signal bundle between the board button / game logic and roll_button_ctrl.
//   key_n      raw active-low push button
//   lock       high = ignore new presses
//   roll_pulse one-cycle roll strobe
//   roll_level debounced pressed level of an unlocked press
//   roll_count rolls issued since reset (zero unless ROLL_COUNT_EN)
// master: the side driving the button and lock; slave: the controller.
interface roll_button_ctrl_if;
    import dice_pkg::*;

    logic                  key_n;
    logic                  lock;
    logic                  roll_pulse;
    logic                  roll_level;
    logic [ROLL_CNT_W-1:0] roll_count;

    modport master (
        output key_n,
        output lock,
        input  roll_pulse,
        input  roll_level,
        input  roll_count
    );

    modport slave (
        input  key_n,
        input  lock,
        output roll_pulse,
        output roll_level,
        output roll_count
    );

endinterface

// File: rtl/btn_sync.sv
// Multi-flop synchroniser for an asynchronous button input.
//   clock  system clock
//   reset  asynchronous active-low reset; chain resets to released (1)
//   d      asynchronous input
//   q      synchronised output, STAGES cycles later
module btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/roll_button_ctrl.sv
// Turns the raw active-low ROLL button into a clean roll strobe for the
// dice game FSM: synchronise, debounce, one event per physical press, and
// suppress presses that start while the game logic holds lock.
//   clock   system clock
//   reset   asynchronous active-low reset
//   bus     roll_button_ctrl_if.slave (key_n, lock in; roll_pulse,
//           roll_level, roll_count out)
// Optional feature: define ROLL_COUNT_EN to build a saturating roll counter
// on roll_count; otherwise roll_count is tied to zero.
module roll_button_ctrl
    import dice_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    roll_button_ctrl_if.slave    bus
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic      key_sync;
    logic      pressed;
    state_e    state_q,  state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic      locked_q, locked_d;
    logic      pulse_q,  pulse_d;
    logic      level_q,  level_d;

    btn_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.key_n),
        .q     (key_sync)
    );

    assign pressed = ~key_sync;

    // Debounce FSM. The counter only runs in the two check states and is
    // cleared on every state change; lock is captured only when a press is
    // accepted, so later lock changes never affect the current hold.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        pulse_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    locked_d = bus.lock;
                    pulse_d  = ~bus.lock;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Level is computed from the next state so it rises with the pulse.
        level_d = ((state_d == HELD) || (state_d == REL_CHK)) && !locked_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            level_q  <= level_d;
        end
    end

    assign bus.roll_pulse = pulse_q;
    assign bus.roll_level = level_q;

`ifdef ROLL_COUNT_EN
    logic [ROLL_CNT_W-1:0] count_q, count_d;

    // Counts alongside the pulse being issued and sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (pulse_d && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.roll_count = count_q;
`else
    assign bus.roll_count = '0;
`endif

endmodule

// File: tb/tb_roll_button_ctrl.sv
// Self-checking bench for roll_button_ctrl with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. A run-length debounce model predicts every output on
// every cycle; directed scenarios add literal expectations on latency,
// pulse counts, level duration, saturation and asynchronous reset.
module tb_roll_button_ctrl;
    import dice_pkg::*;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    roll_button_ctrl_if bus ();

    roll_button_ctrl #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .DB_W            (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: the synced key is the raw key delayed by SYNC edges;
    // a new level is accepted once the synced value has disagreed with the
    // accepted level on DB+1 consecutive edges.
    int  hist [SYNC];
    bit  acc       = 1'b0;
    int  run       = 0;
    bit  m_locked  = 1'b0;
    bit  e_pulse   = 1'b0;
    bit  e_level   = 1'b0;
    int  e_count   = 0;
    bit  s_pressed;

    initial begin
        for (int i = 0; i < SYNC; i++) hist[i] = 1;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 1;
            acc      = 1'b0;
            run      = 0;
            m_locked = 1'b0;
            e_pulse  = 1'b0;
            e_level  = 1'b0;
            e_count  = 0;
        end else begin
            s_pressed = (hist[SYNC-1] == 0);
            for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(bus.key_n);
            e_pulse = 1'b0;
            if (s_pressed != acc) run++;
            else run = 0;
            if (run == DB + 1) begin
                run = 0;
                acc = s_pressed;
                if (acc) begin
                    m_locked = bus.lock;
                    e_pulse  = !m_locked;
                    if (!m_locked && e_count < 255) e_count++;
                end
                e_level = acc && !m_locked;
            end
        end
    end

    function automatic int exp_count();
`ifdef ROLL_COUNT_EN
        return e_count;
`else
        return 0;
`endif
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        check_output("model_pulse", int'(bus.roll_pulse), int'(e_pulse));
        check_output("model_level", int'(bus.roll_level), int'(e_level));
        check_output("model_count", int'(bus.roll_count), exp_count());
    end

    // Activity monitors used by the directed scenarios.
    int  pulses      = 0;
    int  level_highs = 0;
    always @(negedge clock) begin
        if (bus.roll_pulse) pulses++;
        if (bus.roll_level) level_highs++;
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic apply_stimulus(input int hold, input bit lk, input int gap);
        @(negedge clock);
        bus.lock  = lk;
        bus.key_n = 1'b0;
        idle_cycles(hold);
        bus.key_n = 1'b1;
        idle_cycles(gap);
    endtask

    int first_pulse;
    int lvl_cnt;
    int pls_cnt;
    bit level_dropped;

    initial begin
        bus.key_n = 1'b1;
        bus.lock  = 1'b0;

        // 1. reset for 3 cycles, then idle
        idle_cycles(3);
        check_output("reset_pulse", int'(bus.roll_pulse), 0);
        check_output("reset_level", int'(bus.roll_level), 0);
        check_output("reset_count", int'(bus.roll_count), 0);
        reset = 1'b1;
        idle_cycles(5);
        check_output("idle_pulse", int'(bus.roll_pulse), 0);
        check_output("idle_level", int'(bus.roll_level), 0);

        // 2. clean press held 20 cycles
        first_pulse = -1;
        lvl_cnt     = 0;
        pls_cnt     = 0;
        @(negedge clock);
        bus.key_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (bus.roll_pulse) begin
                pls_cnt++;
                if (first_pulse < 0) first_pulse = k;
            end
            if (bus.roll_level) lvl_cnt++;
            if (k == 20) bus.key_n = 1'b1;
        end
        check_output("press_latency", first_pulse, 7);
        check_output("press_pulse_width", pls_cnt, 1);
        check_output("press_level_cycles", lvl_cnt, 20);
`ifdef ROLL_COUNT_EN
        check_output("press_count", int'(bus.roll_count), 1);
`else
        check_output("press_count", int'(bus.roll_count), 0);
`endif

        // 3. short glitches
        pulses = 0; level_highs = 0;
        for (int i = 0; i < 5; i++) apply_stimulus(2, 1'b0, 8);
        check_output("glitch_pulses", pulses, 0);
        check_output("glitch_level", level_highs, 0);

        // 4. locked press, lock drops mid-hold
        pulses = 0; level_highs = 0;
        @(negedge clock);
        bus.lock  = 1'b1;
        bus.key_n = 1'b0;
        idle_cycles(10);
        bus.lock = 1'b0;
        idle_cycles(10);
        bus.key_n = 1'b1;
        idle_cycles(12);
        check_output("locked_pulses", pulses, 0);
        check_output("locked_level", level_highs, 0);
        apply_stimulus(12, 1'b0, 12);
        check_output("unlock_pulses", pulses, 1);

        // 5. release bounce during HELD, with lock rising mid-hold
        pulses = 0;
        level_dropped = 1'b0;
        @(negedge clock);
        bus.key_n = 1'b0;
        idle_cycles(10);
        bus.lock  = 1'b1;
        bus.key_n = 1'b1;
        idle_cycles(2);
        bus.key_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (!bus.roll_level) level_dropped = 1'b1;
        end
        bus.key_n = 1'b1;
        bus.lock  = 1'b0;
        idle_cycles(12);
        check_output("bounce_pulses", pulses, 1);
        check_output("bounce_level_drop", int'(level_dropped), 0);

        // random stimulus
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            bus.key_n = 1'($urandom_range(0, 1));
            bus.lock  = 1'($urandom_range(0, 3) == 0);
            idle_cycles($urandom_range(0, 8));
        end
        bus.key_n = 1'b1;
        bus.lock  = 1'b0;
        idle_cycles(12);

        // 6. saturation
        for (int i = 0; i < 260; i++) apply_stimulus(7, 1'b0, 8);
`ifdef ROLL_COUNT_EN
        check_output("sat_count", int'(bus.roll_count), 255);
`else
        check_output("sat_count", int'(bus.roll_count), 0);
`endif

        // async reset while the press is held (level high)
        @(negedge clock);
        bus.key_n = 1'b0;
        idle_cycles(10);
        check_output("held_level", int'(bus.roll_level), 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_output("async_pulse", int'(bus.roll_pulse), 0);
        check_output("async_level", int'(bus.roll_level), 0);
        check_output("async_count", int'(bus.roll_count), 0);
        idle_cycles(2);
        reset = 1'b1;
        pulses = 0;
        idle_cycles(14);
        check_output("requalify_pulses", pulses, 1);

        // async reset in the middle of press qualification
        bus.key_n = 1'b1;
        idle_cycles(12);
        @(negedge clock);
        bus.key_n = 1'b0;
        idle_cycles(4);
        #1 reset = 1'b0;
        #1;
        check_output("pchk_reset_pulse", int'(bus.roll_pulse), 0);
        check_output("pchk_reset_level", int'(bus.roll_level), 0);
        check_output("pchk_reset_count", int'(bus.roll_count), 0);
        idle_cycles(2);
        reset = 1'b1;
        pulses = 0;
        idle_cycles(14);
        check_output("pchk_requalify", pulses, 1);
        bus.key_n = 1'b1;
        idle_cycles(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
